vec_mem_arbiter: RTL

- Single-port arbiter and sequencer for the 8 KiB vector RAM shared by three requesters:
  - ROM download writer (dl_*),
  - 6502 CPU accesses through the address decoder (cpu_*),
  - AVG instruction fetch (fetch_*).
- Replaces the ad-hoc write mux and the dual-read instruction pipe. The RAM becomes a plain 1R/W synchronous single-port macro driven only by this block.
- Sits between addrDecoder/avg_core and the vector RAM, in the core clock domain.

---
 rtl/vec_mem_pkg.sv | 22 ++
 rtl/vec_fetch_seq.sv | 100 ++++++++++
 rtl/vec_mem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vec_mem_pkg.sv
// Shared types and defaults for the vector RAM arbiter and its fetch sequencer.
package vec_mem_pkg;

    localparam int          ADDR_W_DEF     = 13;
    localparam logic [15:0] VEC_BASE_DEF   = 16'h2000;
    localparam logic [12:0] ROM_OFFSET_DEF = 13'h1000;

    typedef enum logic [1:0] {
        F_IDLE,
        F_EVEN,
        F_ODD,
        F_WAIT
    } fetch_state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_CPU,
        TAG_EVEN,
        TAG_ODD
    } rd_tag_t;

endpackage

// File: rtl/vec_fetch_seq.sv
// AVG instruction fetch sequencer: latches the word address, issues the even
// and odd byte reads as grants allow, and assembles the 16-bit instruction.
module vec_fetch_seq
    import vec_mem_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter logic [15:0] VEC_BASE = VEC_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              fetch_req,
    input  logic [15:0]       fetch_addr,
    input  logic              fetch_abort,
    input  logic              beat_grant,
    input  rd_tag_t           rd_tag,
    input  logic [7:0]        mem_rdata,
    output logic              beat_req,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              fetch_ack,
    output logic              fetch_valid,
    output logic [15:0]       fetch_data
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-2:0] word_q, word_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       data_q, data_d;
    logic              ack_q, ack_d;
    logic              valid_q, valid_d;

    logic [15:0] rel_addr;
    logic        unused_bits;

    assign rel_addr    = fetch_addr - VEC_BASE;
    assign unused_bits = ^{rel_addr[15:ADDR_W], rel_addr[0]};

    // Abort cancels the beat in the same cycle so no stale byte is requested.
    assign beat_req  = !fetch_abort && (state_q == F_EVEN || state_q == F_ODD);
    assign beat_addr = {word_q, state_q == F_ODD};

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        hi_d    = hi_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        valid_d = 1'b0;
        if (fetch_abort) begin
            state_d = F_IDLE;
        end else begin
            case (state_q)
                F_IDLE: begin
                    if (fetch_req) begin
                        word_d  = rel_addr[ADDR_W-1:1];
                        ack_d   = 1'b1;
                        state_d = F_EVEN;
                    end
                end
                F_EVEN: begin
                    if (beat_grant) state_d = F_ODD;
                end
                F_ODD: begin
                    if (rd_tag == TAG_EVEN) hi_d = mem_rdata;
                    if (beat_grant) state_d = F_WAIT;
                end
                F_WAIT: begin
                    if (rd_tag == TAG_ODD) begin
                        data_d  = {hi_q, mem_rdata};
                        valid_d = 1'b1;
                    end
                    state_d = F_IDLE;
                end
                default: state_d = F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= F_IDLE;
            word_q  <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
        end
    end

    assign fetch_ack   = ack_q;
    assign fetch_valid = valid_q;
    assign fetch_data  = data_q;

endmodule

// File: rtl/vec_mem_arbiter.sv
// Single-port vector RAM arbiter: download writes, buffered CPU accesses and
// AVG instruction fetch share one RAM port with fixed priority dl > CPU > fetch.
module vec_mem_arbiter
    import vec_mem_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [15:0]       VEC_BASE   = VEC_BASE_DEF,
    parameter logic [ADDR_W-1:0] ROM_OFFSET = ROM_OFFSET_DEF
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              clk_3MHz_en,
    input  logic              dl_wr,
    input  logic [11:0]       dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_overrun,
    input  logic              fetch_req,
    input  logic [15:0]       fetch_addr,
    input  logic              fetch_abort,
    output logic              fetch_ack,
    output logic              fetch_valid,
    output logic [15:0]       fetch_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    logic              busy_q, busy_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [7:0]        op_wdata_q, op_wdata_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        rdata_q, rdata_d;
    rd_tag_t           tag_q, tag_d;

    logic              dl_grant;
    logic              cpu_grant;
    logic              fetch_grant;
    logic              capture;
    logic [15:0]       cpu_rel;
    logic [ADDR_W-1:0] dl_ram_addr;
    logic              beat_req;
    logic [ADDR_W-1:0] beat_addr;
    logic              unused_hi;

    assign cpu_rel     = cpu_addr - VEC_BASE;
    assign unused_hi   = ^cpu_rel[15:ADDR_W];
    assign dl_ram_addr = ADDR_W'(dl_addr) + ROM_OFFSET;
    assign capture     = clk_3MHz_en && (cpu_we || cpu_re);

    // dl_wr is gated by reset so the RAM port stays quiet while rst_l is low.
    assign dl_grant    = rst_l && dl_wr;
    assign cpu_grant   = !dl_wr && busy_q;
    assign fetch_grant = !dl_wr && !busy_q && beat_req;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        tag_d     = TAG_NONE;
        if (dl_grant) begin
            mem_addr  = dl_ram_addr;
            mem_we    = 1'b1;
            mem_wdata = dl_data;
        end else if (cpu_grant) begin
            mem_addr  = op_addr_q;
            mem_we    = op_we_q;
            mem_wdata = op_we_q ? op_wdata_q : 8'h00;
            tag_d     = op_we_q ? TAG_NONE : TAG_CPU;
        end else if (fetch_grant) begin
            mem_addr  = beat_addr;
            tag_d     = beat_addr[0] ? TAG_ODD : TAG_EVEN;
        end
    end

    // A capture while the previous op is still waiting overwrites it; an op
    // being issued this very cycle is not lost, so that is not an overrun.
    always_comb begin
        busy_d     = busy_q && !cpu_grant;
        op_we_d    = op_we_q;
        op_addr_d  = op_addr_q;
        op_wdata_d = op_wdata_q;
        overrun_d  = overrun_q;
        if (capture) begin
            busy_d     = 1'b1;
            op_we_d    = cpu_we;
            op_addr_d  = cpu_rel[ADDR_W-1:0];
            op_wdata_d = cpu_wdata;
            if (busy_q && !cpu_grant) overrun_d = 1'b1;
        end
        rdata_d = (tag_q == TAG_CPU) ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            busy_q     <= 1'b0;
            op_we_q    <= 1'b0;
            op_addr_q  <= '0;
            op_wdata_q <= '0;
            overrun_q  <= 1'b0;
            rdata_q    <= '0;
            tag_q      <= TAG_NONE;
        end else begin
            busy_q     <= busy_d;
            op_we_q    <= op_we_d;
            op_addr_q  <= op_addr_d;
            op_wdata_q <= op_wdata_d;
            overrun_q  <= overrun_d;
            rdata_q    <= rdata_d;
            tag_q      <= tag_d;
        end
    end

    assign cpu_busy    = busy_q;
    assign cpu_overrun = overrun_q;
    assign cpu_rdata   = rdata_q;

    vec_fetch_seq #(
        .ADDR_W   (ADDR_W),
        .VEC_BASE (VEC_BASE)
    ) u_fetch (
        .clk         (clk),
        .rst_l       (rst_l),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_abort (fetch_abort),
        .beat_grant  (fetch_grant),
        .rd_tag      (tag_q),
        .mem_rdata   (mem_rdata),
        .beat_req    (beat_req),
        .beat_addr   (beat_addr),
        .fetch_ack   (fetch_ack),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data)
    );

endmodule
